ode_euler_ctrl: RTL and testbench
=================================

# ode_euler_ctrl

Sequencing controller for the ODE solver's fixed-point Euler integrator. It owns one shared multiply-accumulate datapath and steps it row by row through the product A·X. Each row's dot product is scaled by h and added to the state, and the controller repeats this for a programmable number of steps. It sits between the solver top level, which supplies the start command, matrix, step size and initial state, and the result/error reporting path.

## Interface
- N, 4, system order; A is N×N, X is N elements
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- num_steps  in  16  number of Euler steps S, unsigned
- h  in  16  step size, signed Q8.8
- A  in  16·N·N  A[i][k] at bits [16·(i·N+k) +: 16], signed Q8.8
- X0  in  16·N  X[k] at bits [16·k +: 16], signed Q8.8
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; X_out valid
- X_out  out  16·N  final state, same packing as X0; held until next done
- step_count  out  16  completed steps in current run
- error  out  1  sticky overflow flag for current run

## Operation
- States: IDLE, MAC, UPD, COMMIT, DONE.
- IDLE + start:
  - Capture A, h, X0 into X, and num_steps.
  - Clear error and step_count; set row=0, col=0, acc=0.
  - Go to DONE if S=0, else go to MAC.
- MAC, one product per cycle: acc ← acc + A[row][col]·X[col]; col++. After the col=N−1 accumulation, go to UPD.
- UPD: Xn[row] ← X[row] + h·acc; acc←0; col←0.
  - If row=N−1, go to COMMIT; else row++ and go to MAC.
- COMMIT: X ← Xn (Jacobi update: every row uses the old X); step_count++; row←0.
  - If the new step_count = S, go to DONE; else go to MAC.
- DONE: X_out ← X; done=1; go to IDLE.
- start outside IDLE is ignored, with no queuing.
- Inputs other than start are don't-care after the capture cycle.
- Arithmetic:
  - Multiply: 16×16 signed gives 32-bit Q16.16; the result is product[23:8] (truncation). Overflow when product[31:23] are not all equal.
  - Add: 16-bit signed; overflow when the operand signs match and the sum sign differs.
  - Every multiply and add (MAC, h·acc, X+d) sets error on overflow. error clears only at the next accepted start or at reset.
- Reset, including mid-run:
  - State returns to IDLE.
  - busy=0, done=0, error=0, step_count=0, X_out=0, and internal X/Xn/acc are cleared.
  - An aborted run produces no done.

## Timing
- Per step: N·(N+1)+1 cycles (N rows × (N MAC + 1 UPD) + 1 COMMIT).
- Let t0 be the edge that samples start.
  - done is high during exactly one cycle, the one following edge t0 + S·(N²+N+1).
  - For S=0 that is the cycle immediately after t0.
- busy rises the cycle after t0 and falls the cycle after done.
- X_out and step_count (final value S) are valid in the done cycle and stable thereafter.
- Back-to-back runs: start asserted in the cycle after done is accepted.

## Configuration
- ODE_SAT_EN defined: any overflowing multiply or add result is replaced by 0x7FFF (positive overflow) or 0x8000 (negative overflow) before use. error is still set.
- ODE_SAT_EN undefined: results wrap (two's-complement truncation to 16 bits). error is still set.

## Test plan
- N=2, A=I (0x0100 diagonal, 0 elsewhere), h=0x0080, X0=(0x0200,0xFF00), S=1 → done 7 edges after t0, X_out=(0x0300,0xFE80), error=0, step_count=1.
- N=2, A=I, h=0x0080, X0=(0x0100,0x0100), S=3 → X_out=(0x0360,0x0360), done 21 edges after t0.
- S=0, X0=(0x1234,0x0042) → done the cycle after t0, X_out=X0, busy never seen high together with MAC activity.
- A all 0x7F00, X0 all 0x7F00, h=0x0100, S=1:
  - with ODE_SAT_EN → error=1, X_out all 0x7FFF;
  - without → error=1, wrapped values.
- reset asserted 5 cycles into an S=2 run → next cycle busy=0, X_out=0, error=0; no done; a fresh start then completes normally.
- start pulsed again mid-run with different X0 → ignored; result matches the first run's inputs.

Source files
------------

// File: rtl/ode_euler_ctrl.sv
// rtl/ode_euler_ctrl.sv - Euler integrator sequencer over a shared MAC datapath (ODE_SAT_EN selects saturating arithmetic)

module ode_euler_ctrl #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       num_steps,
    input  logic [15:0]       h,
    input  logic [16*N*N-1:0] A,
    input  logic [16*N-1:0]   X0,
    output logic              busy,
    output logic              done,
    output logic [16*N-1:0]   X_out,
    output logic [15:0]       step_count,
    output logic              error
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        UPD,
        COMMIT,
        DONE
    } state_t;

    state_t state;

    // Captured run parameters and integrator state
    logic signed [15:0] a_r  [N][N];
    logic signed [15:0] x_r  [N];
    logic signed [15:0] xn_r [N];
    logic signed [15:0] h_r;
    logic signed [15:0] acc;
    logic [15:0]        ns_r;
    logic [IW-1:0]      row;
    logic [IW-1:0]      col;

    // Shared multiply/add datapath signals
    logic signed [15:0] mul_a;
    logic signed [15:0] mul_b;
    logic signed [31:0] prod;
    logic signed [15:0] mul_res;
    logic               mul_ovf;
    logic signed [15:0] add_a;
    logic signed [15:0] sum;
    logic signed [15:0] add_res;
    logic               add_ovf;
    logic [15:0]        step_next;

    assign step_next = step_count + 16'd1;

    // One multiplier and one adder: MAC computes acc + A*X, UPD reuses them for X + h*acc
    always_comb begin
        mul_a = a_r[row][col];
        mul_b = x_r[col];
        add_a = acc;
        if (state == UPD) begin
            mul_a = h_r;
            mul_b = acc;
            add_a = x_r[row];
        end

        // Q8.8 x Q8.8 -> Q16.16; keep the middle 16 bits, overflow if the top 9 bits disagree
        prod    = mul_a * mul_b;
        mul_ovf = (prod > 32'sh007F_FFFF) || (prod < 32'shFF80_0000);
        mul_res = prod[23:8];
`ifdef ODE_SAT_EN
        if (mul_ovf) begin
            mul_res = prod[31] ? 16'sh8000 : 16'sh7FFF;
        end
`endif

        sum     = add_a + mul_res;
        add_ovf = (add_a[15] == mul_res[15]) && (sum[15] != add_a[15]);
        add_res = sum;
`ifdef ODE_SAT_EN
        if (add_ovf) begin
            add_res = add_a[15] ? 16'sh8000 : 16'sh7FFF;
        end
`endif
    end

    // Sequencer: row-by-row MAC, per-row update into Xn, then a Jacobi commit per step
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            step_count <= 16'd0;
            X_out      <= '0;
            h_r        <= '0;
            ns_r       <= '0;
            acc        <= '0;
            row        <= '0;
            col        <= '0;
            for (int i = 0; i < N; i++) begin
                x_r[i]  <= '0;
                xn_r[i] <= '0;
                for (int k = 0; k < N; k++) begin
                    a_r[i][k] <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            x_r[i] <= X0[16*i +: 16];
                            for (int k = 0; k < N; k++) begin
                                a_r[i][k] <= A[16*(i*N+k) +: 16];
                            end
                        end
                        h_r        <= h;
                        ns_r       <= num_steps;
                        error      <= 1'b0;
                        step_count <= 16'd0;
                        row        <= '0;
                        col        <= '0;
                        acc        <= '0;
                        busy       <= 1'b1;
                        if (num_steps == 16'd0) begin
                            // Nothing to integrate: report the initial state straight away
                            X_out <= X0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= MAC;
                        end
                    end
                end

                MAC: begin
                    acc   <= add_res;
                    error <= error | mul_ovf | add_ovf;
                    if (col == LAST) begin
                        col   <= '0;
                        state <= UPD;
                    end else begin
                        col <= col + IW'(1);
                    end
                end

                UPD: begin
                    xn_r[row] <= add_res;
                    error     <= error | mul_ovf | add_ovf;
                    acc       <= '0;
                    col       <= '0;
                    if (row == LAST) begin
                        state <= COMMIT;
                    end else begin
                        row   <= row + IW'(1);
                        state <= MAC;
                    end
                end

                COMMIT: begin
                    // All rows were computed from the old X; only now does X advance
                    for (int k = 0; k < N; k++) begin
                        x_r[k] <= xn_r[k];
                    end
                    step_count <= step_next;
                    row        <= '0;
                    if (step_next == ns_r) begin
                        for (int k = 0; k < N; k++) begin
                            X_out[16*k +: 16] <= xn_r[k];
                        end
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= MAC;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ode_euler_ctrl.sv
// tb/tb_ode_euler_ctrl.sv - scoreboard bench for ode_euler_ctrl with a behavioural Euler model

module tb_ode_euler_ctrl;

    localparam int N   = 2;
    localparam int LAT = N*N + N + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [15:0]       num_steps;
    logic [15:0]       h;
    logic [16*N*N-1:0] A;
    logic [16*N-1:0]   X0;
    logic              busy;
    logic              done;
    logic [16*N-1:0]   X_out;
    logic [15:0]       step_count;
    logic              error;

    ode_euler_ctrl #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_steps  (num_steps),
        .h          (h),
        .A          (A),
        .X0         (X0),
        .busy       (busy),
        .done       (done),
        .X_out      (X_out),
        .step_count (step_count),
        .error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [16*N-1:0] x;
        logic            err;
        logic [15:0]     sc;
        int              t_done;
    } exp_t;

    exp_t q[$];

    logic signed [15:0] cur_a [N*N];
    logic signed [15:0] cur_x [N];
    logic signed [15:0] cur_h;
    int                 cur_s;
    bit                 m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int wrap16(input int v);
        int r;
        r = v & 32'h0000_FFFF;
        if (r >= 32768) r = r - 65536;
        return r;
    endfunction

    // Q8.8 product: exact value must lie within the representable Q16.16 window of 24 bits
    function automatic int mulq(input int a, input int b);
        int p;
        p = a * b;
        if (p > 8388607 || p < -8388608) begin
            m_err = 1'b1;
`ifdef ODE_SAT_EN
            return (p > 0) ? 32767 : -32768;
`endif
        end
        return wrap16(p >>> 8);
    endfunction

    function automatic int addq(input int a, input int b);
        int s;
        s = a + b;
        if (s > 32767 || s < -32768) begin
            m_err = 1'b1;
`ifdef ODE_SAT_EN
            return (s > 0) ? 32767 : -32768;
`endif
        end
        return wrap16(s);
    endfunction

    // Explicit Euler with a Jacobi update: X(n+1) = X(n) + h * (A X(n))
    function automatic void model(output logic [16*N-1:0] xo, output bit err);
        int xs [N];
        int xn [N];
        int acc;
        m_err = 1'b0;
        for (int k = 0; k < N; k++) xs[k] = cur_x[k];
        for (int s = 0; s < cur_s; s++) begin
            for (int i = 0; i < N; i++) begin
                acc = 0;
                for (int k = 0; k < N; k++) acc = addq(acc, mulq(cur_a[i*N+k], xs[k]));
                xn[i] = addq(xs[i], mulq(cur_h, acc));
            end
            for (int k = 0; k < N; k++) xs[k] = xn[k];
        end
        for (int k = 0; k < N; k++) xo[16*k +: 16] = 16'(xs[k]);
        err = m_err;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
            end else begin
                e = q.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.t_done));
                check("x_out", 64'(X_out), 64'(e.x));
                check("error", 64'(error), 64'(e.err));
                check("step_count", 64'(step_count), 64'(e.sc));
            end
        end
    end

    task automatic set_identity();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
                cur_a[i*N+k] = (i == k) ? 16'sh0100 : 16'sh0000;
    endtask

    task automatic issue(input bit expect_done, input bit directed,
                         input logic [16*N-1:0] dx, input logic derr);
        exp_t            e;
        logic [16*N-1:0] mx;
        bit              merr;
        @(posedge clk);
        #1;
        for (int i = 0; i < N*N; i++) A[16*i +: 16] = cur_a[i];
        for (int k = 0; k < N; k++) X0[16*k +: 16] = cur_x[k];
        h         = cur_h;
        num_steps = 16'(cur_s);
        start     = 1'b1;
        if (expect_done) begin
            model(mx, merr);
            e.x      = directed ? dx : mx;
            e.err    = directed ? derr : merr;
            e.sc     = 16'(cur_s);
            e.t_done = cyc + 1 + cur_s * LAT;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        A         = {$urandom(), $urandom()};
        X0        = $urandom();
        h         = 16'($urandom());
        num_steps = 16'($urandom());
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_run();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL run_timeout: %0d results outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        num_steps = '0;
        h         = '0;
        A         = '0;
        X0        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_x_out", 64'(X_out), 64'd0);
        check("rst_step_count", 64'(step_count), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        reset = 1'b0;

        // Identity, one step with h = 0.5
        set_identity();
        cur_x[0] = 16'sh0200; cur_x[1] = 16'shFF00; cur_h = 16'sh0080; cur_s = 1;
        issue(1'b1, 1'b1, {16'hFE80, 16'h0300}, 1'b0);
        wait_run();

        // Identity, three steps: each step multiplies by 1.5
        cur_x[0] = 16'sh0100; cur_x[1] = 16'sh0100; cur_s = 3;
        issue(1'b1, 1'b1, {16'h0360, 16'h0360}, 1'b0);
        wait_run();

        // Zero steps returns X0 on the very next cycle
        cur_x[0] = 16'sh1234; cur_x[1] = 16'sh0042; cur_s = 0;
        issue(1'b1, 1'b1, {16'h0042, 16'h1234}, 1'b0);
        wait_run();

        // Overflow on every stage
        for (int i = 0; i < N*N; i++) cur_a[i] = 16'sh7F00;
        cur_x[0] = 16'sh7F00; cur_x[1] = 16'sh7F00; cur_h = 16'sh0100; cur_s = 1;
`ifdef ODE_SAT_EN
        issue(1'b1, 1'b1, {16'h7FFF, 16'h7FFF}, 1'b1);
`else
        issue(1'b1, 1'b1, {16'h8100, 16'h8100}, 1'b1);
`endif
        wait_run();

        // Mid-run reset: run aborts silently, outputs clear
        set_identity();
        cur_x[0] = 16'sh0200; cur_x[1] = 16'sh0300; cur_h = 16'sh0080; cur_s = 2;
        issue(1'b0, 1'b0, '0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_x_out", 64'(X_out), 64'd0);
        check("abort_error", 64'(error), 64'd0);
        check("abort_step_count", 64'(step_count), 64'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        issue(1'b1, 1'b0, '0, 1'b0);
        wait_run();

        // start pulsed mid-run with other data must be ignored
        cur_x[0] = 16'sh0200; cur_x[1] = 16'shFF00; cur_h = 16'sh0080; cur_s = 1;
        issue(1'b1, 1'b1, {16'hFE80, 16'h0300}, 1'b0);
        @(posedge clk);
        #1;
        X0    = {16'h1111, 16'h2222};
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_run();

        // Randomized runs, mostly in range with occasional full-scale values
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < N*N; i++)
                cur_a[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom())
                                                       : 16'(int'($urandom_range(0, 1023)) - 512);
            for (int k = 0; k < N; k++)
                cur_x[k] = ($urandom_range(0, 3) == 0) ? 16'($urandom())
                                                       : 16'(int'($urandom_range(0, 4095)) - 2048);
            cur_h = 16'(int'($urandom_range(0, 511)) - 256);
            cur_s = int'($urandom_range(0, 3));
            issue(1'b1, 1'b0, '0, 1'b0);
            wait_run();
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
